// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and constants for the triangle dispatch path.
//   TRI_WIDTH              bits per assembled triangle (vertices + color)
//   FRAME_START/FRAME_END  levels of the frame_end marker input
//   disp_state_t           dispatcher frame-sequencing states
//   tri_t                  one assembled triangle
package gpu_pkg;
    localparam int TRI_WIDTH = 168;

    localparam logic FRAME_START = 1'b0;
    localparam logic FRAME_END   = 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} disp_state_t;

    typedef logic [TRI_WIDTH-1:0] tri_t;
endpackage

// File: rtl/tri_dispatcher_if.sv
// tri_dispatcher_if: assembler-side and rasterizer-side signals of the
// dispatcher.
//   enable, frame_end             host frame control
//   texel_buffer/ready/read       assembler ready/read handshake
//   lane_busy/lane_start/lane_tri rasterizer lane array
//   frame_done, tri_count         frame status
// modport master: the dispatcher; modport slave: its environment.
interface tri_dispatcher_if #(
    parameter int NUM_LANES = 4,
    parameter int TRI_WIDTH = 168,
    parameter int CNT_WIDTH = 16
);
    logic                 enable;
    logic                 frame_end;
    logic [TRI_WIDTH-1:0] texel_buffer;
    logic                 texel_ready;
    logic                 texel_read;
    logic [NUM_LANES-1:0] lane_busy;
    logic [NUM_LANES-1:0] lane_start;
    logic [TRI_WIDTH-1:0] lane_tri;
    logic                 frame_done;
    logic [CNT_WIDTH-1:0] tri_count;

    modport master (
        input  enable, frame_end, texel_buffer, texel_ready, lane_busy,
        output texel_read, lane_start, lane_tri, frame_done, tri_count
    );

    modport slave (
        output enable, frame_end, texel_buffer, texel_ready, lane_busy,
        input  texel_read, lane_start, lane_tri, frame_done, tri_count
    );
endinterface

// File: rtl/tri_dispatcher_fifo.sv
// tri_fifo: synchronous FIFO for buffered triangles.
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, din     write port (caller never pushes when full)
//   pop, dout     read port; dout is the head entry, valid when !empty
//   full, empty   decoded from the registered occupancy count
module tri_fifo #(
    parameter int W     = 168,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap for free.
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/tri_dispatcher.sv
// tri_dispatcher: drains triangles from the assembler into a small FIFO and
// hands them round-robin to the rasterizer lanes, sequencing each frame
// through IDLE -> RUN -> DRAIN -> DONE.
//   clk, rst  clock, synchronous active-high reset
//   bus       tri_dispatcher_if.master (assembler handshake, lane array,
//             frame control and status)
module tri_dispatcher
    import gpu_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int TRI_WIDTH  = gpu_pkg::TRI_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input logic              clk,
    input logic              rst,
    tri_dispatcher_if.master bus
);
    localparam int LW = $clog2(NUM_LANES);

    disp_state_t          state, state_nxt;
    logic                 guard;
    logic [LW-1:0]        rr_ptr, sel;
    logic [LW:0]          idx;
    logic                 found, dispatch;
    logic                 fifo_full, fifo_empty;
    logic [TRI_WIDTH-1:0] head;

    // guard hides the assembler's ready level for the cycle it needs to
    // drop it after a read.
    assign bus.texel_read = bus.texel_ready & bus.enable & (state == RUN)
                          & ~fifo_full & ~guard;
    assign bus.frame_done = (state == DONE);

    tri_fifo #(.W(TRI_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.texel_read),
        .din   (bus.texel_buffer),
        .pop   (dispatch),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // First free lane from rr_ptr upward. A lane started last cycle still
    // shows busy low, so lane_start masks it too.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = {1'b0, rr_ptr} + (LW+1)'(k);
            if (idx >= (LW+1)'(NUM_LANES))
                idx = idx - (LW+1)'(NUM_LANES);
            if (!found && !bus.lane_busy[idx[LW-1:0]] && !bus.lane_start[idx[LW-1:0]]) begin
                found = 1'b1;
                sel   = idx[LW-1:0];
            end
        end
    end

    assign dispatch = ((state == RUN) || (state == DRAIN)) && !fifo_empty && found;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.enable) state_nxt = RUN;
            RUN:     if (bus.frame_end) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty && bus.lane_busy == '0 && bus.lane_start == '0)
                         state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            guard          <= 1'b0;
            rr_ptr         <= '0;
            bus.lane_start <= '0;
            bus.lane_tri   <= '0;
            bus.tri_count  <= '0;
        end else begin
            state          <= state_nxt;
            guard          <= bus.texel_read;
            bus.lane_start <= dispatch ? (NUM_LANES'(1) << sel) : '0;
            if (dispatch) begin
                bus.lane_tri <= head;
                rr_ptr       <= (sel == LW'(NUM_LANES-1)) ? '0 : sel + LW'(1);
            end
            // Count persists through DONE/IDLE until the next frame opens.
            if (state == IDLE && bus.enable)
                bus.tri_count <= '0;
            else if (bus.texel_read && bus.tri_count != '1)
                bus.tri_count <= bus.tri_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: doc/tri_dispatcher.md
Name: tri_dispatcher

Overview:
- Frame-level controller that drains 168-bit assembled triangles from the triangle assembler using its ready/read handshake.
- Buffers triangles in a small FIFO and dispatches them round-robin to NUM_LANES rasterizer lanes.
- Sequences frame start, drain and completion for the rest of the 3D pipeline.
- Sits between the assembler and the rasterizer array.

Parameters:
- NUM_LANES, 4, number of rasterizer lanes (2..8).
- TRI_WIDTH, 168, bits per triangle (vertices + color).
- FIFO_DEPTH, 4, triangle buffer entries (power of two, at least 2).
- CNT_WIDTH, 16, width of the per-frame triangle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  host permission to start/continue a frame.
- frame_end  in  1  one-cycle pulse: no more triangles in this frame.
- texel_buffer  in  TRI_WIDTH  assembled triangle from the assembler.
- texel_ready  in  1  assembler holds a complete triangle (level).
- texel_read  out  1  one-cycle pulse: triangle consumed.
- lane_busy  in  NUM_LANES  per-lane busy, rises the cycle after lane_start.
- lane_start  out  NUM_LANES  registered one-hot, one-cycle start pulse.
- lane_tri  out  TRI_WIDTH  registered triangle, valid with lane_start.
- frame_done  out  1  one-cycle pulse: frame fully rasterized.
- tri_count  out  CNT_WIDTH  triangles accepted in the current frame.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE; FIFO emptied; rr_ptr = 0; read guard cleared.
  - All outputs 0: texel_read, lane_start, lane_tri, frame_done, tri_count.
  - Reset mid-frame discards buffered triangles; lanes are not notified.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: enable = 1 -> RUN, and tri_count clears to 0 on that transition.
  - RUN:
    - frame_end = 1 -> DRAIN.
    - enable = 0 pauses acceptance only; dispatch continues and state stays RUN.
  - DRAIN: FIFO empty, lane_busy == 0 and lane_start == 0 -> DONE.
  - DONE: frame_done = 1 for one cycle -> IDLE. tri_count holds until the next frame starts.
- Accept (combinational texel_read):
  - texel_read = texel_ready & enable & state == RUN & !fifo_full & !guard.
  - guard is a register set for one cycle after any texel_read. It masks the stale texel_ready level while the assembler leaves its wait state.
  - On texel_read, texel_buffer is pushed into the FIFO and tri_count increments.
  - tri_count saturates at all-ones; it does not wrap.
  - Accept and frame_end in the same RUN cycle: the triangle is accepted and counted, then the state goes to DRAIN.
  - No accepts occur in DRAIN, DONE or IDLE.
- FIFO:
  - fifo_full and fifo_empty are computed from the registered count; there is no bypass.
  - A push when full is impossible by construction.
  - Push and pop in the same cycle leaves the count unchanged and both take effect.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Dispatch:
  - Each cycle, in states RUN or DRAIN, if the FIFO is not empty, find the first lane i searching from rr_ptr upward (wrapping).
  - Lane i must satisfy !lane_busy[i] & !lane_start[i]. The lane_start term masks a lane started last cycle whose busy has not risen yet.
  - If a lane is found: pop the FIFO head, lane_start[i] <= 1 next cycle, lane_tri <= head, rr_ptr <= (i+1) mod NUM_LANES.
  - At most one dispatch per cycle.
  - lane_tri holds its last value when no start is issued.
- Latency:
  - A triangle accepted in cycle t enters the FIFO at the t edge.
  - Earliest dispatch decision is cycle t+1; lane_start is seen in cycle t+2.
- A frame with zero triangles (frame_end with no accepts) reaches DONE with tri_count = 0.

Decomposition:
- gpu_pkg holds:
  - TRI_WIDTH and the FRAME_START/FRAME_END marker constants (0, 1).
  - The dispatcher state enum.
  - A tri_t typedef of logic [TRI_WIDTH-1:0].
- One sub-module, tri_fifo: parameterized synchronous FIFO with push, pop, full, empty, head data and synchronous active-high reset.
- The round-robin search stays inline in tri_dispatcher.

Test Plan:
- Reset mid-RUN with 3 triangles buffered:
  - All outputs 0 the next cycle; FIFO empty; state IDLE.
  - No lane_start follows.
- enable = 1, assembler offers triangles A, B, C, D with all lanes idle:
  - texel_read pulses are never back-to-back.
  - lane_start sequence is 0001, 0010, 0100, 1000 carrying A..D.
  - tri_count = 4.
- lane_busy = 1111 while 6 triangles arrive:
  - Exactly FIFO_DEPTH = 4 are accepted, then texel_read stays low.
  - Releasing lane 2 yields lane_start = 0100 with the oldest triangle, and acceptance resumes.
- lane 1 busy, rr_ptr = 1, FIFO holding 2 triangles: dispatch skips to lane 2 then lane 3, and rr_ptr ends at 0.
- frame_end coincident with the 5th accept:
  - tri_count = 5 and DRAIN is entered.
  - frame_done pulses once, exactly one cycle after the FIFO is empty and lane_busy == 0.
  - tri_count holds 5 in IDLE.
- frame_end with no triangles: frame_done pulses 2 cycles later and tri_count = 0.
